// File: rtl/alu_cmd_driver_pkg.sv
// Shared definitions for the ALU command driver: function codes and FSM states.
package alu_cmd_driver_pkg;

    localparam int unsigned FXN_W = 3;

    localparam logic [FXN_W-1:0] FXN_PASSX = 3'b000;
    localparam logic [FXN_W-1:0] FXN_PASSY = 3'b001;
    localparam logic [FXN_W-1:0] FXN_NEGX  = 3'b010;
    localparam logic [FXN_W-1:0] FXN_NEGY  = 3'b011;
    localparam logic [FXN_W-1:0] FXN_GE    = 3'b100;
    localparam logic [FXN_W-1:0] FXN_XOR   = 3'b101;
    localparam logic [FXN_W-1:0] FXN_ADD   = 3'b110;
    localparam logic [FXN_W-1:0] FXN_SUB   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_ovf_counter.sv
// Saturating event counter with synchronous clear; clear has priority over increment.
module alu_ovf_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && !(&count_q)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/alu_cmd_driver.sv
// Drives one command at a time into an external combinational ALU and holds
// the captured result for a ready/valid consumer; tracks an accumulator.
module alu_cmd_driver
    import alu_cmd_driver_pkg::*;
#(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_fxn,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_use_acc,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic [2:0]       alu_fxn,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow,
    input  logic             alu_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_overflow,
    output logic             rsp_cout,
    output logic [WIDTH-1:0] acc,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             cnt_clr
);

    state_e           state_q, state_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] alu_x_q, alu_x_d;
    logic [WIDTH-1:0] alu_y_q, alu_y_d;
    logic [2:0]       alu_fxn_q, alu_fxn_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_overflow_q, rsp_overflow_d;
    logic             rsp_cout_q, rsp_cout_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             accept;
    logic             capture;

    // Next state, handshake flags and datapath loads
    always_comb begin
        state_d        = state_q;
        alu_x_d        = alu_x_q;
        alu_y_d        = alu_y_q;
        alu_fxn_d      = alu_fxn_q;
        rsp_result_d   = rsp_result_q;
        rsp_overflow_d = rsp_overflow_q;
        rsp_cout_d     = rsp_cout_q;
        acc_d          = acc_q;
        accept         = 1'b0;
        capture        = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    accept    = 1'b1;
                    state_d   = EXEC;
                    alu_x_d   = cmd_use_acc ? acc_q : cmd_a;
                    alu_y_d   = cmd_b;
                    alu_fxn_d = cmd_fxn;
                end
            end
            EXEC: begin
                capture        = 1'b1;
                state_d        = RESP;
                rsp_result_d   = alu_result;
                rsp_overflow_d = alu_overflow;
                rsp_cout_d     = alu_cout;
                acc_d          = alu_result;
            end
            RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cmd_ready_q    <= 1'b1;
            rsp_valid_q    <= 1'b0;
            alu_x_q        <= '0;
            alu_y_q        <= '0;
            alu_fxn_q      <= '0;
            rsp_result_q   <= '0;
            rsp_overflow_q <= 1'b0;
            rsp_cout_q     <= 1'b0;
            acc_q          <= '0;
        end else begin
            state_q        <= state_d;
            cmd_ready_q    <= cmd_ready_d;
            rsp_valid_q    <= rsp_valid_d;
            alu_x_q        <= alu_x_d;
            alu_y_q        <= alu_y_d;
            alu_fxn_q      <= alu_fxn_d;
            rsp_result_q   <= rsp_result_d;
            rsp_overflow_q <= rsp_overflow_d;
            rsp_cout_q     <= rsp_cout_d;
            acc_q          <= acc_d;
        end
    end

    alu_ovf_counter #(
        .CNT_W (CNT_W)
    ) u_ovf_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (cnt_clr),
        .inc_i   (capture && alu_overflow),
        .count_o (ovf_count)
    );

    assign cmd_ready    = cmd_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign alu_x        = alu_x_q;
    assign alu_y        = alu_y_q;
    assign alu_fxn      = alu_fxn_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_overflow = rsp_overflow_q;
    assign rsp_cout     = rsp_cout_q;
    assign acc          = acc_q;

    logic unused_ok;
    assign unused_ok = accept;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver with a behavioural 6-bit ALU attached.
module tb_alu_cmd_driver;
    import alu_cmd_driver_pkg::*;

    localparam int unsigned W  = 6;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_fxn = '0;
    logic [W-1:0]  cmd_a = '0;
    logic [W-1:0]  cmd_b = '0;
    logic          cmd_use_acc = 1'b0;
    logic [W-1:0]  alu_x, alu_y;
    logic [2:0]    alu_fxn;
    logic [W-1:0]  alu_result;
    logic          alu_overflow, alu_cout;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [W-1:0]  rsp_result;
    logic          rsp_overflow, rsp_cout;
    logic [W-1:0]  acc;
    logic [CW-1:0] ovf_count;
    logic          cnt_clr = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_cmd_driver #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_fxn(cmd_fxn),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
        .alu_x(alu_x), .alu_y(alu_y), .alu_fxn(alu_fxn),
        .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_overflow(rsp_overflow), .rsp_cout(rsp_cout),
        .acc(acc), .ovf_count(ovf_count), .cnt_clr(cnt_clr)
    );

    // Behavioural two's-complement ALU
    logic [W:0] sum;
    always_comb begin
        sum          = '0;
        alu_result   = '0;
        alu_overflow = 1'b0;
        alu_cout     = 1'b0;
        case (alu_fxn)
            FXN_PASSX: alu_result = alu_x;
            FXN_PASSY: alu_result = alu_y;
            FXN_NEGX: begin
                alu_result   = W'(-alu_x);
                alu_overflow = (alu_x == 6'b100000);
            end
            FXN_NEGY: begin
                alu_result   = W'(-alu_y);
                alu_overflow = (alu_y == 6'b100000);
            end
            FXN_GE:  alu_result = ($signed(alu_x) >= $signed(alu_y)) ? 6'd1 : 6'd0;
            FXN_XOR: alu_result = alu_x ^ alu_y;
            FXN_ADD: begin
                sum          = {1'b0, alu_x} + {1'b0, alu_y};
                alu_result   = sum[W-1:0];
                alu_cout     = sum[W];
                alu_overflow = (alu_x[W-1] == alu_y[W-1]) && (sum[W-1] != alu_x[W-1]);
            end
            default: begin
                sum          = {1'b0, alu_x} + {1'b0, ~alu_y} + 7'd1;
                alu_result   = sum[W-1:0];
                alu_cout     = sum[W];
                alu_overflow = (alu_x[W-1] != alu_y[W-1]) && (sum[W-1] != alu_x[W-1]);
            end
        endcase
    end

    typedef struct {
        logic [2:0]   fxn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         use_acc;
        logic [W-1:0] res;
        logic         ovf;
        logic         cout;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Issue one command from a negedge; returns in RESP (rdy=0) or after the handshake
    task automatic do_cmd(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ua, input logic clr, input logic rdy);
        int n;
        cmd_valid   = 1'b1;
        cmd_fxn     = f;
        cmd_a       = a;
        cmd_b       = b;
        cmd_use_acc = ua;
        rsp_ready   = rdy;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("cmd_ready_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cnt_clr   = clr;
        chk("exec_rsp_valid", int'(rsp_valid), 0);
        chk("exec_cmd_ready", int'(cmd_ready), 0);
        @(negedge clk);
        cnt_clr = 1'b0;
        chk("resp_rsp_valid", int'(rsp_valid), 1);
        if (rdy) begin
            @(negedge clk);
            chk("hs_rsp_valid", int'(rsp_valid), 0);
            chk("hs_cmd_ready", int'(cmd_ready), 1);
        end
    endtask

    initial begin
        int exp_cnt;
        logic [W-1:0] exp_acc;

        vecs[0]  = '{FXN_ADD,   6'd20, 6'd15, 1'b0, 6'b100011, 1'b1, 1'b0};
        vecs[1]  = '{FXN_SUB,   6'd5,  6'd7,  1'b0, 6'b111110, 1'b0, 1'b0};
        vecs[2]  = '{FXN_PASSX, 6'd9,  6'd0,  1'b1, 6'b111110, 1'b0, 1'b0};
        vecs[3]  = '{FXN_PASSY, 6'd3,  6'd9,  1'b0, 6'd9,      1'b0, 1'b0};
        vecs[4]  = '{FXN_NEGX,  6'd5,  6'd0,  1'b0, 6'd59,     1'b0, 1'b0};
        vecs[5]  = '{FXN_NEGY,  6'd0,  6'd32, 1'b0, 6'd32,     1'b1, 1'b0};
        vecs[6]  = '{FXN_GE,    6'd63, 6'd1,  1'b0, 6'd0,      1'b0, 1'b0};
        vecs[7]  = '{FXN_GE,    6'd1,  6'd63, 1'b0, 6'd1,      1'b0, 1'b0};
        vecs[8]  = '{FXN_GE,    6'd7,  6'd7,  1'b0, 6'd1,      1'b0, 1'b0};
        vecs[9]  = '{FXN_XOR,   6'd42, 6'd21, 1'b0, 6'd63,     1'b0, 1'b0};
        vecs[10] = '{FXN_ADD,   6'd63, 6'd1,  1'b0, 6'd0,      1'b0, 1'b1};
        vecs[11] = '{FXN_SUB,   6'd32, 6'd1,  1'b0, 6'd31,     1'b1, 1'b1};
        vecs[12] = '{FXN_ADD,   6'd0,  6'd1,  1'b1, 6'd32,     1'b1, 1'b0};

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_alu_x", int'(alu_x), 0);
        chk("rst_alu_fxn", int'(alu_fxn), 0);
        chk("rst_acc", int'(acc), 0);
        chk("rst_ovf_count", int'(ovf_count), 0);
        rst_n = 1'b1;
        @(negedge clk);

        exp_cnt = 0;
        exp_acc = '0;
        for (int i = 0; i < 13; i++) begin
            do_cmd(vecs[i].fxn, vecs[i].a, vecs[i].b, vecs[i].use_acc, 1'b0, 1'b1);
            chk("vec_alu_x", int'(alu_x), int'(vecs[i].use_acc ? exp_acc : vecs[i].a));
            chk("vec_alu_y", int'(alu_y), int'(vecs[i].b));
            chk("vec_alu_fxn", int'(alu_fxn), int'(vecs[i].fxn));
            chk("vec_result", int'(rsp_result), int'(vecs[i].res));
            chk("vec_overflow", int'(rsp_overflow), int'(vecs[i].ovf));
            chk("vec_cout", int'(rsp_cout), int'(vecs[i].cout));
            chk("vec_acc", int'(acc), int'(vecs[i].res));
            exp_acc = vecs[i].res;
            if (vecs[i].ovf) exp_cnt++;
            chk("vec_ovf_count", int'(ovf_count), exp_cnt);
        end

        // Backpressure with a second command held on the input
        chk("bp_start_ready", int'(cmd_ready), 1);
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_fxn = FXN_ADD; cmd_a = 6'd1; cmd_b = 6'd2; cmd_use_acc = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cmd_fxn = FXN_XOR; cmd_a = 6'd5; cmd_b = 6'd3;
        chk("bp_exec_ready", int'(cmd_ready), 0);
        @(negedge clk);
        chk("bp_resp_valid", int'(rsp_valid), 1);
        chk("bp_resp_result", int'(rsp_result), 3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", int'(rsp_valid), 1);
            chk("bp_hold_result", int'(rsp_result), 3);
            chk("bp_hold_ready", int'(cmd_ready), 0);
            chk("bp_hold_alu_fxn", int'(alu_fxn), int'(FXN_ADD));
            chk("bp_hold_alu_x", int'(alu_x), 1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_hs_valid", int'(rsp_valid), 0);
        chk("bp_hs_ready", int'(cmd_ready), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("bp_second_fxn", int'(alu_fxn), int'(FXN_XOR));
        chk("bp_second_y", int'(alu_y), 3);
        @(negedge clk);
        chk("bp_second_valid", int'(rsp_valid), 1);
        chk("bp_second_result", int'(rsp_result), 6);
        @(negedge clk);

        // Saturation of the overflow counter, then clear coinciding with a capture
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        chk("sat_pre_clear", int'(ovf_count), 0);
        for (int i = 0; i < 17; i++) begin
            do_cmd(FXN_ADD, 6'd31, 6'd1, 1'b0, 1'b0, 1'b1);
            chk("sat_count", int'(ovf_count), (i + 1 > 15) ? 15 : i + 1);
        end
        chk("sat_result", int'(rsp_result), 32);
        chk("sat_overflow", int'(rsp_overflow), 1);
        do_cmd(FXN_ADD, 6'd31, 6'd1, 1'b0, 1'b1, 1'b1);
        chk("sat_clr_wins", int'(ovf_count), 0);

        // Compare result, then reset while the response is pending
        do_cmd(FXN_GE, 6'b111111, 6'b000001, 1'b0, 1'b0, 1'b0);
        chk("cmp_result", int'(rsp_result), 0);
        chk("cmp_valid", int'(rsp_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_rsp_valid", int'(rsp_valid), 0);
        chk("abort_acc", int'(acc), 0);
        chk("abort_cmd_ready", int'(cmd_ready), 1);
        chk("abort_alu_x", int'(alu_x), 0);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", int'(rsp_valid), 0);
            chk("abort_idle", int'(cmd_ready), 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
